// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the pulse timing channels.
package freq_meas_pkg;

  typedef enum logic {ARMED = 1'b0, RUN = 1'b1} state_t;

  localparam int SAT_W = 32;

  // Returns {overflow, min(a+b, max_val)}; callers zero-extend narrower operands.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input logic [SAT_W-1:0] max_val);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_val}) return {1'b1, max_val};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/freq_capture_channel.sv
// One pulse channel: 2-flop synchroniser plus edge flop, high/low timing FSM,
// timeout handling and block averager of the measured period.
module freq_capture_channel
  import freq_meas_pkg::*;
#(
  parameter int COUNTER_BITS = 15,
  parameter int AVG_LOG2     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    freq_in,
  output logic [COUNTER_BITS-1:0] time_high,
  output logic [COUNTER_BITS-1:0] time_low,
  output logic [COUNTER_BITS-1:0] period,
  output logic [COUNTER_BITS-1:0] period_avg,
  output logic                    meas_valid,
  output logic                    avg_valid,
  output logic                    overflow
);

  localparam logic [COUNTER_BITS-1:0] MAX = '1;
  localparam int ACC_W = COUNTER_BITS + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic                    s1, s2, s3;
  logic                    rise, level;
  state_t                  state;
  logic [COUNTER_BITS-1:0] hi_cnt, lo_cnt;
  logic [ACC_W-1:0]        acc, avg_sum;
  logic [CNT_W-1:0]        avg_cnt;
  logic [SAT_W:0]          sum_sat;
  logic [COUNTER_BITS-1:0] meas_per;
  logic                    meas_ovf, blk_last;

  assign rise  = s2 & ~s3;
  assign level = s2;

  // Upper bits of the saturated sum are zero whenever the flag is clear.
  assign sum_sat  = sat_add(SAT_W'(hi_cnt), SAT_W'(lo_cnt), SAT_W'(MAX));
  assign meas_ovf = sum_sat[SAT_W] | (|sum_sat[SAT_W-1:COUNTER_BITS]);
  assign meas_per = sum_sat[COUNTER_BITS-1:0];
  assign avg_sum  = acc + ACC_W'(meas_per);
  assign blk_last = (avg_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= ARMED;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      acc        <= '0;
      avg_cnt    <= '0;
      time_high  <= '0;
      time_low   <= '0;
      period     <= '0;
      period_avg <= '0;
      meas_valid <= 1'b0;
      avg_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1         <= freq_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      avg_valid  <= 1'b0;
      if (!enable) begin
        state   <= ARMED;
        hi_cnt  <= '0;
        lo_cnt  <= '0;
        acc     <= '0;
        avg_cnt <= '0;
      end else begin
        unique case (state)
          ARMED: begin
            lo_cnt <= '0;
            if (rise) begin
              hi_cnt <= COUNTER_BITS'(1);
              state  <= RUN;
            end else begin
              hi_cnt <= '0;
            end
          end
          RUN: begin
            if (rise) begin
              time_high  <= hi_cnt;
              time_low   <= lo_cnt;
              period     <= meas_per;
              overflow   <= meas_ovf;
              meas_valid <= 1'b1;
              hi_cnt     <= COUNTER_BITS'(1);
              lo_cnt     <= '0;
              if (meas_ovf) begin
                acc     <= '0;
                avg_cnt <= '0;
              end else if (blk_last) begin
                period_avg <= COUNTER_BITS'(avg_sum >> AVG_LOG2);
                avg_valid  <= 1'b1;
                acc        <= '0;
                avg_cnt    <= '0;
              end else begin
                acc     <= avg_sum;
                avg_cnt <= avg_cnt + CNT_W'(1);
              end
            end else if (hi_cnt == MAX || lo_cnt == MAX) begin
              // DC or too-slow input: report saturation and wait for a fresh edge.
              time_high  <= MAX;
              time_low   <= MAX;
              period     <= MAX;
              overflow   <= 1'b1;
              meas_valid <= 1'b1;
              hi_cnt     <= '0;
              lo_cnt     <= '0;
              acc        <= '0;
              avg_cnt    <= '0;
              state      <= ARMED;
            end else if (level) begin
              hi_cnt <= hi_cnt + COUNTER_BITS'(1);
            end else begin
              lo_cnt <= lo_cnt + COUNTER_BITS'(1);
            end
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: rtl/freq_capture_array.sv
// Array of independent pulse timing channels; channel i owns bus slice
// [i*COUNTER_BITS +: COUNTER_BITS] of every result bus.
module freq_capture_array
  import freq_meas_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int COUNTER_BITS = 15,
  parameter int AVG_LOG2     = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CHANNELS-1:0]              ENABLE,
  input  logic [CHANNELS-1:0]              FREQ_IN,
  output logic [CHANNELS*COUNTER_BITS-1:0] TIME_HIGH,
  output logic [CHANNELS*COUNTER_BITS-1:0] TIME_LOW,
  output logic [CHANNELS*COUNTER_BITS-1:0] PERIOD,
  output logic [CHANNELS*COUNTER_BITS-1:0] PERIOD_AVG,
  output logic [CHANNELS-1:0]              MEAS_VALID,
  output logic [CHANNELS-1:0]              AVG_VALID,
  output logic [CHANNELS-1:0]              OVERFLOW
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    freq_capture_channel #(
      .COUNTER_BITS(COUNTER_BITS),
      .AVG_LOG2    (AVG_LOG2)
    ) u_ch (
      .clk       (CLK),
      .rst       (RST),
      .enable    (ENABLE[i]),
      .freq_in   (FREQ_IN[i]),
      .time_high (TIME_HIGH [i*COUNTER_BITS +: COUNTER_BITS]),
      .time_low  (TIME_LOW  [i*COUNTER_BITS +: COUNTER_BITS]),
      .period    (PERIOD    [i*COUNTER_BITS +: COUNTER_BITS]),
      .period_avg(PERIOD_AVG[i*COUNTER_BITS +: COUNTER_BITS]),
      .meas_valid(MEAS_VALID[i]),
      .avg_valid (AVG_VALID[i]),
      .overflow  (OVERFLOW[i])
    );
  end

endmodule
